// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode codes, sequencer state encoding and the top legal opcode
// shared by the command sequencer and its decoder.
package ctrl_pkg;

   localparam int unsigned OP_ADD     = 1;
   localparam int unsigned OP_SUB     = 2;
   localparam int unsigned OP_MUL     = 3;
   localparam int unsigned OP_AND     = 4;
   localparam int unsigned OP_OR      = 5;
   localparam int unsigned OP_NOT     = 6;
   localparam int unsigned OP_XOR     = 7;
   localparam int unsigned OP_SHL     = 8;
   localparam int unsigned OP_SHR     = 9;
   localparam int unsigned OP_GT      = 10;
   localparam int unsigned OP_LT      = 11;
   localparam int unsigned OP_EQ      = 12;
   localparam int unsigned OP_CNT_SET = 13;
   localparam int unsigned OP_CNT_INC = 14;
   localparam int unsigned OP_CNT_DEC = 15;

   localparam int unsigned OP_MAX     = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder. Codes 1..OP_MAX map straight
// onto the ALU select with a register write; anything else (zero, above
// OP_MAX, or with high bits set) is flagged illegal with all controls low.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int CMD_W  = 16,
   parameter int CTRL_W = 8
) (
   input  logic [CMD_W-1:0]  code,
   output logic [CTRL_W-1:0] alu_control,
   output logic              regwrite_control,
   output logic              illegal
);

   logic legal;

   // A code is legal only if the full-width value lies in 1..OP_MAX.
   always_comb begin
      legal            = (code != '0) && (code <= CMD_W'(OP_MAX));
      alu_control      = legal ? code[CTRL_W-1:0] : '0;
      regwrite_control = legal;
      illegal          = ~legal;
   end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: single-command sequencer. Accepts one command in IDLE, spends a
// down-counted number of cycles in EXEC (MUL_LAT for MUL, one otherwise),
// then presents the registered decode in DONE until the consumer takes it.
// Illegal codes skip EXEC. Optional performance counters are built only
// when CTRL_PERF_CNT_EN is defined; otherwise the count ports tie to 0.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high, controls zero
// EXEC  | command executing, cycle counter running down to 0
// DONE  | decoded control word offered, held until out_ready
module ctrl_seq
   import ctrl_pkg::*;
#(
   parameter int CMD_W   = 16,
   parameter int CTRL_W  = 8,
   parameter int MUL_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   input  logic [CMD_W-1:0]  cmd_code,
   output logic              cmd_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] alu_control,
   output logic              regwrite_control,
   output logic              illegal,
   output logic [31:0]       cmd_count,
   output logic [31:0]       illegal_count
);

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CTRL_W-1:0] alu_q, alu_d;
   logic              rw_q, rw_d;
   logic              ill_q, ill_d;

   logic [CTRL_W-1:0] dec_alu;
   logic              dec_rw;
   logic              dec_ill;

   ctrl_decode #(
      .CMD_W  (CMD_W),
      .CTRL_W (CTRL_W)
   ) u_decode (
      .code             (cmd_code),
      .alu_control      (dec_alu),
      .regwrite_control (dec_rw),
      .illegal          (dec_ill)
   );

   // State, cycle counter and decoded-control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         alu_q   <= '0;
         rw_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         alu_q   <= alu_d;
         rw_q    <= rw_d;
         ill_q   <= ill_d;
      end
   end

   // Next-state logic; controls load on accept and clear on handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      alu_d   = alu_q;
      rw_d    = rw_q;
      ill_d   = ill_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               alu_d = dec_alu;
               rw_d  = dec_rw;
               ill_d = dec_ill;
               if (dec_ill) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_EXEC;
                  cnt_d   = (cmd_code == CMD_W'(OP_MUL)) ? CNT_W'(MUL_LAT - 1) : '0;
               end
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
               alu_d   = '0;
               rw_d    = 1'b0;
               ill_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            alu_d   = '0;
            rw_d    = 1'b0;
            ill_d   = 1'b0;
         end
      endcase
   end

   assign cmd_ready        = (state_q == ST_IDLE);
   assign out_valid        = (state_q == ST_DONE);
   assign alu_control      = alu_q;
   assign regwrite_control = rw_q;
   assign illegal          = ill_q;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cmd_cnt_q;
   logic [31:0] ill_cnt_q;
   logic        hs;

   assign hs = out_valid & out_ready;

   // Completed-command counters; wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_cnt_q <= '0;
         ill_cnt_q <= '0;
      end else if (hs) begin
         cmd_cnt_q <= cmd_cnt_q + 32'd1;
         if (ill_q) ill_cnt_q <= ill_cnt_q + 32'd1;
      end
   end

   assign cmd_count     = cmd_cnt_q;
   assign illegal_count = ill_cnt_q;
`else
   assign cmd_count     = '0;
   assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed vector table plus hand-written sequences for the
// stall, reset-in-flight and counter cases of ctrl_seq.
module tb_ctrl_seq;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic [15:0] cmd_code;
   logic        cmd_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  alu_control;
   logic        regwrite_control;
   logic        illegal;
   logic [31:0] cmd_count;
   logic [31:0] illegal_count;

   int n_pass = 0;
   int n_total = 0;
   int exp_cmd = 0;
   int exp_ill = 0;

   typedef struct {
      logic [15:0] code;
      int          lat;
      logic [7:0]  alu;
      logic        rw;
      logic        ill;
   } vec_t;

   vec_t vecs[10];

   ctrl_seq #(.CMD_W(16), .CTRL_W(8), .MUL_LAT(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_valid        (cmd_valid),
      .cmd_code         (cmd_code),
      .cmd_ready        (cmd_ready),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .alu_control      (alu_control),
      .regwrite_control (regwrite_control),
      .illegal          (illegal),
      .cmd_count        (cmd_count),
      .illegal_count    (illegal_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic chk_counters(input string name);
`ifdef CTRL_PERF_CNT_EN
      chk({name, "_cmd_count"}, cmd_count, exp_cmd);
      chk({name, "_illegal_count"}, illegal_count, exp_ill);
`else
      chk({name, "_cmd_count"}, cmd_count, 32'd0);
      chk({name, "_illegal_count"}, illegal_count, 32'd0);
`endif
   endtask

   task automatic do_cmd(input vec_t v, input int idx);
      int   lat;
      logic ready_low;
      string tag;
      tag = $sformatf("vec%0d_code%0h", idx, v.code);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_code  = v.code;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_code  = 16'h0001;
      lat = 1;
      ready_low = 1'b1;
      while (!out_valid && lat < 20) begin
         if (cmd_ready) ready_low = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (cmd_ready) ready_low = 1'b0;
      chk({tag, "_latency"}, lat, v.lat);
      chk({tag, "_alu"}, alu_control, v.alu);
      chk({tag, "_regwrite"}, regwrite_control, v.rw);
      chk({tag, "_illegal"}, illegal, v.ill);
      chk({tag, "_ready_low"}, ready_low, 1'b1);
      @(posedge clk);
      #1;
      exp_cmd++;
      if (v.ill) exp_ill++;
      chk({tag, "_ready_after"}, cmd_ready, 1'b1);
      chk({tag, "_valid_after"}, out_valid, 1'b0);
      chk({tag, "_alu_idle"}, alu_control, 8'h00);
   endtask

   initial begin
      logic stable;
      logic never_valid;
      int   lat;

      vecs[0] = '{16'h0001, 2, 8'h01, 1'b1, 1'b0};
      vecs[1] = '{16'h0003, 5, 8'h03, 1'b1, 1'b0};
      vecs[2] = '{16'h0000, 1, 8'h00, 1'b0, 1'b1};
      vecs[3] = '{16'h0010, 1, 8'h00, 1'b0, 1'b1};
      vecs[4] = '{16'h8005, 1, 8'h00, 1'b0, 1'b1};
      vecs[5] = '{16'h0007, 2, 8'h07, 1'b1, 1'b0};
      vecs[6] = '{16'h000F, 2, 8'h0F, 1'b1, 1'b0};
      vecs[7] = '{16'h00FF, 1, 8'h00, 1'b0, 1'b1};
      vecs[8] = '{16'h0105, 1, 8'h00, 1'b0, 1'b1};
      vecs[9] = '{16'h000D, 2, 8'h0D, 1'b1, 1'b0};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_code  = 16'h0000;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_alu", alu_control, 8'h00);
      chk("reset_regwrite", regwrite_control, 1'b0);
      chk("reset_illegal", illegal, 1'b0);
      chk_counters("reset");

      for (int i = 0; i < 10; i++) do_cmd(vecs[i], i);
      chk_counters("after_table");

      // Stall in DONE with out_ready low and a competing command offered.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_code  = 16'h000E;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      cmd_code = 16'h0001;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("hold_latency", lat, 2);
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (!out_valid || alu_control !== 8'h0E || regwrite_control !== 1'b1 ||
             illegal !== 1'b0 || cmd_ready !== 1'b0) stable = 1'b0;
      end
      chk("hold_stable", stable, 1'b1);
      chk("hold_alu", alu_control, 8'h0E);
      chk_counters("hold_before_release");
      @(negedge clk);
      cmd_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_cmd++;
      chk("hold_release_ready", cmd_ready, 1'b1);
      chk("hold_release_valid", out_valid, 1'b0);
      chk_counters("hold_after_release");

      // Reset while MUL is executing.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_code  = 16'h0003;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_exec_valid", out_valid, 1'b0);
      chk("rst_exec_alu", alu_control, 8'h03);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_alu", alu_control, 8'h00);
      chk("rst_async_regwrite", regwrite_control, 1'b0);
      chk("rst_async_valid", out_valid, 1'b0);
      exp_cmd = 0;
      exp_ill = 0;
      chk_counters("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      never_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (out_valid || !cmd_ready) never_valid = 1'b0;
      end
      chk("rst_no_completion", never_valid, 1'b1);
      chk_counters("rst_after");

      // Three legal and two illegal commands from a fresh count.
      do_cmd(vecs[0], 0);
      do_cmd(vecs[2], 2);
      do_cmd(vecs[1], 1);
      do_cmd(vecs[4], 4);
      do_cmd(vecs[5], 5);
`ifdef CTRL_PERF_CNT_EN
      chk("perf_cmd_count", cmd_count, 32'd5);
      chk("perf_illegal_count", illegal_count, 32'd2);
`else
      chk("perf_cmd_count", cmd_count, 32'd0);
      chk("perf_illegal_count", illegal_count, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
